pll_sequencer: RTL and testbench

Startup and reconfiguration sequencer for the digital PLL (ring oscillator plus frequency-lock controller). It runs on the external oscillator clock and drives the PLL enable, reset, DCO mode, divider and trim inputs. It also owns the select line of the downstream glitch-free core clock mux. It guarantees that the core never runs on the PLL clock before the PLL has had time to settle, and that every configuration change is applied with the core parked on the external clock.

---
 rtl/pll_seq_pkg.sv | 22 ++
 rtl/pll_sequencer_sync2.sv | 24 ++
 rtl/pll_sequencer.sv | 177 +++++++++++++++++
 tb/tb_pll_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared state type and default constants for the PLL sequencer
package pll_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        SETTLE,
        SWITCH,
        RUN,
        UNSWITCH,
        FAULT
    } state_t;

    localparam int          RESET_CYCLES_DEF  = 16;
    localparam int          SETTLE_CYCLES_DEF = 4096;
    localparam int          ACK_TIMEOUT_DEF   = 64;
    localparam int          CNT_W_DEF         = 13;
    localparam int          DIV_W             = 5;
    localparam int          TRIM_W            = 26;
    localparam logic [4:0]  DIV_RST_DEF       = 5'd8;

endpackage

// File: rtl/pll_sequencer_sync2.sv
// rtl/pll_sequencer_sync2.sv - two-flop synchronizer for the clock-mux acknowledge
module sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_sequencer.sv
// rtl/pll_sequencer.sv - PLL bring-up / reconfiguration sequencer owning the core clock-mux select
module pll_sequencer
    import pll_seq_pkg::*;
#(
    parameter int         RESET_CYCLES  = RESET_CYCLES_DEF,
    parameter int         SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int         ACK_TIMEOUT   = ACK_TIMEOUT_DEF,
    parameter int         CNT_W         = CNT_W_DEF,
    parameter logic [4:0] DIV_RST       = DIV_RST_DEF
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              start,
    input  logic              stop,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_dco,
    input  logic [TRIM_W-1:0] cfg_trim,
    input  logic              mux_ack,
    output logic              pll_enable,
    output logic              pll_resetb,
    output logic              pll_dco,
    output logic [DIV_W-1:0]  pll_div,
    output logic [TRIM_W-1:0] pll_trim,
    output logic              use_pll,
    output logic              locked,
    output logic              fault
);

    localparam logic [CNT_W-1:0] LD_RST    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_ACK    = CNT_W'(ACK_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_load;
    logic               w_cnt_zero;
    logic               r_relock;
    logic               w_relock_next;
    logic               w_ack_s;
    logic               w_hs;
    logic               w_copy;

    logic               r_pll_enable;
    logic               r_pll_resetb;
    logic               r_use_pll;
    logic               r_locked;
    logic               r_fault;
    logic               r_cfg_ready;
    logic               r_pll_dco;
    logic [DIV_W-1:0]   r_pll_div;
    logic [TRIM_W-1:0]  r_pll_trim;
    logic               r_sh_dco;
    logic [DIV_W-1:0]   r_sh_div;
    logic [TRIM_W-1:0]  r_sh_trim;

    sync2 u_ack_sync (
        .i_clk   (clock),
        .i_rst_n (resetb),
        .i_d     (mux_ack),
        .o_q     (w_ack_s)
    );

    assign w_cnt_zero = (r_cnt == '0);
    assign w_hs       = cfg_valid & r_cfg_ready;

    always_comb begin
        w_next        = r_state;
        w_relock_next = r_relock;
        case (r_state)
            IDLE:     if (start && !stop) w_next = RST;
            RST:      if (stop) w_next = IDLE;
                      else if (w_cnt_zero) w_next = SETTLE;
            SETTLE:   if (stop) w_next = IDLE;
                      else if (w_cnt_zero) w_next = SWITCH;
            SWITCH: begin
                if (stop) begin
                    w_next        = UNSWITCH;
                    w_relock_next = 1'b0;
                end else if (w_ack_s) begin
                    w_next = RUN;
                end else if (w_cnt_zero) begin
                    w_next = FAULT;
                end
            end
            RUN: begin
                // stop wins over a same-cycle cfg; the cfg still lands in the shadow
                if (stop) begin
                    w_next        = UNSWITCH;
                    w_relock_next = 1'b0;
                end else if (w_hs) begin
                    w_next        = UNSWITCH;
                    w_relock_next = 1'b1;
                end
            end
            UNSWITCH: if (!w_ack_s) w_next = r_relock ? RST : IDLE;
                      else if (w_cnt_zero) w_next = FAULT;
            FAULT:    if (start && !stop) w_next = RST;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        w_cnt_load = '0;
        case (w_next)
            RST:              w_cnt_load = LD_RST;
            SETTLE:           w_cnt_load = LD_SETTLE;
            SWITCH, UNSWITCH: w_cnt_load = LD_ACK;
            default:          w_cnt_load = '0;
        endcase
    end

    // PLL config follows the shadow while parked, and is latched once per RST entry
    assign w_copy = (r_state == IDLE) || (r_state == FAULT) ||
                    ((w_next == RST) && (r_state != RST));

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_relock <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_relock <= w_relock_next;
            if (w_next != r_state) r_cnt <= w_cnt_load;
            else if (!w_cnt_zero)  r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_pll_enable <= 1'b0;
            r_pll_resetb <= 1'b0;
            r_use_pll    <= 1'b0;
            r_locked     <= 1'b0;
            r_fault      <= 1'b0;
            r_cfg_ready  <= 1'b1;
            r_pll_dco    <= 1'b0;
            r_pll_div    <= DIV_RST;
            r_pll_trim   <= '0;
            r_sh_dco     <= 1'b0;
            r_sh_div     <= DIV_RST;
            r_sh_trim    <= '0;
        end else begin
            r_pll_enable <= (w_next != IDLE) && (w_next != FAULT);
            r_pll_resetb <= (w_next == SETTLE) || (w_next == SWITCH) ||
                            (w_next == RUN)    || (w_next == UNSWITCH);
            r_use_pll    <= (w_next == SWITCH) || (w_next == RUN);
            r_locked     <= (w_next == RUN);
            r_fault      <= (w_next == FAULT);
            r_cfg_ready  <= (w_next == IDLE) || (w_next == RUN) || (w_next == FAULT);
            if (w_copy) begin
                r_pll_dco  <= r_sh_dco;
                r_pll_div  <= r_sh_div;
                r_pll_trim <= r_sh_trim;
            end
            if (w_hs) begin
                r_sh_dco  <= cfg_dco;
                r_sh_div  <= cfg_div;
                r_sh_trim <= cfg_trim;
            end
        end
    end

    assign pll_enable = r_pll_enable;
    assign pll_resetb = r_pll_resetb;
    assign use_pll    = r_use_pll;
    assign locked     = r_locked;
    assign fault      = r_fault;
    assign cfg_ready  = r_cfg_ready;
    assign pll_dco    = r_pll_dco;
    assign pll_div    = r_pll_div;
    assign pll_trim   = r_pll_trim;

endmodule

// File: tb/tb_pll_sequencer.sv
// tb/tb_pll_sequencer.sv - self-checking bench for pll_sequencer with a timeline model and mux echo
module tb_pll_sequencer;

    localparam int RC = 16;
    localparam int SC = 64;
    localparam int AT = 64;

    localparam int P_OFF    = 0;
    localparam int P_HOLD   = 1;
    localparam int P_LOCKW  = 2;
    localparam int P_TOPLL  = 3;
    localparam int P_ONPLL  = 4;
    localparam int P_TOEXT  = 5;
    localparam int P_ERR    = 6;

    logic        clock = 1'b0;
    logic        resetb = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [4:0]  cfg_div = 5'd0;
    logic        cfg_dco = 1'b0;
    logic [25:0] cfg_trim = 26'd0;
    logic        mux_ack;
    logic        cfg_ready, pll_enable, pll_resetb, pll_dco, use_pll, locked, fault;
    logic [4:0]  pll_div;
    logic [25:0] pll_trim;

    int checks = 0;
    int failures = 0;
    int tb_cyc = 0;
    bit cmp_en = 0;
    bit stuck = 0;
    logic [2:0] r_echo = 3'b000;

    always #5 clock = ~clock;

    pll_sequencer #(
        .RESET_CYCLES(RC), .SETTLE_CYCLES(SC), .ACK_TIMEOUT(AT), .CNT_W(13), .DIV_RST(5'd8)
    ) dut (
        .clock(clock), .resetb(resetb), .start(start), .stop(stop),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_div(cfg_div),
        .cfg_dco(cfg_dco), .cfg_trim(cfg_trim), .mux_ack(mux_ack),
        .pll_enable(pll_enable), .pll_resetb(pll_resetb), .pll_dco(pll_dco),
        .pll_div(pll_div), .pll_trim(pll_trim), .use_pll(use_pll),
        .locked(locked), .fault(fault)
    );

    always @(posedge clock) tb_cyc <= tb_cyc + 1;

    // clock mux: select echoed three cycles later unless forced stuck low
    always @(posedge clock) r_echo <= {r_echo[1:0], use_pll};
    assign mux_ack = stuck ? 1'b0 : r_echo[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return pll_enable;
            1: return pll_resetb;
            2: return use_pll;
            3: return locked;
            4: return fault;
            default: return mux_ack;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input logic val, input int budget, output int t);
        int n;
        n = 0;
        t = -1;
        while (sig(sel) !== val && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (sig(sel) === val) begin
            t = tb_cyc;
        end else begin
            checks++;
            failures++;
            $display("FAIL wait_sig%0d: value %0d not seen within %0d cycles", sel, val, budget);
        end
    endtask

    task automatic pulse_start(output int n);
        start = 1'b1;
        @(negedge clock);
        n = tb_cyc;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
    endtask

    // timeline model: current phase, edge of phase entry, two-edge delayed view of mux_ack
    int          ph, t_in, mcyc;
    bit          relock, a1, a2;
    bit          m_sdco, m_edco;
    logic [4:0]  m_sdiv, m_ediv;
    logic [25:0] m_strim, m_etrim;

    always @(posedge clock or negedge resetb) begin : model
        int el, nph;
        bit ack_s, hs, cp;
        if (!resetb) begin
            ph = P_OFF; t_in = mcyc; relock = 0; a1 = 0; a2 = 0;
            m_sdco = 0; m_sdiv = 5'd8; m_strim = '0;
            m_edco = 0; m_ediv = 5'd8; m_etrim = '0;
        end else begin
            mcyc = mcyc + 1;
            el = mcyc - t_in;
            ack_s = a2; a2 = a1; a1 = mux_ack;
            hs = cfg_valid && (ph == P_OFF || ph == P_ONPLL || ph == P_ERR);
            nph = ph;
            case (ph)
                P_OFF:   if (start && !stop) nph = P_HOLD;
                P_HOLD:  if (stop) nph = P_OFF; else if (el == RC) nph = P_LOCKW;
                P_LOCKW: if (stop) nph = P_OFF; else if (el == SC) nph = P_TOPLL;
                P_TOPLL: if (stop) begin nph = P_TOEXT; relock = 0; end
                         else if (ack_s) nph = P_ONPLL;
                         else if (el == AT) nph = P_ERR;
                P_ONPLL: if (stop) begin nph = P_TOEXT; relock = 0; end
                         else if (hs) begin nph = P_TOEXT; relock = 1; end
                P_TOEXT: if (!ack_s) nph = relock ? P_HOLD : P_OFF;
                         else if (el == AT) nph = P_ERR;
                default: if (start && !stop) nph = P_HOLD;
            endcase
            cp = (ph == P_OFF) || (ph == P_ERR) || (nph == P_HOLD && ph != P_HOLD);
            if (cp) begin m_edco = m_sdco; m_ediv = m_sdiv; m_etrim = m_strim; end
            if (hs) begin m_sdco = cfg_dco; m_sdiv = cfg_div; m_strim = cfg_trim; end
            if (nph != ph) t_in = mcyc;
            ph = nph;
        end
    end

    initial mcyc = 0;

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("m_enable",  pll_enable, !(ph == P_OFF || ph == P_ERR));
            chk("m_resetb",  pll_resetb, ph inside {P_LOCKW, P_TOPLL, P_ONPLL, P_TOEXT});
            chk("m_use_pll", use_pll,    ph inside {P_TOPLL, P_ONPLL});
            chk("m_locked",  locked,     ph == P_ONPLL);
            chk("m_fault",   fault,      ph == P_ERR);
            chk("m_ready",   cfg_ready,  ph inside {P_OFF, P_ONPLL, P_ERR});
            chk("m_div",     pll_div,    m_ediv);
            chk("m_dco",     pll_dco,    m_edco);
            chk("m_trim",    pll_trim,   m_etrim);
        end
    end

    initial begin
        int ns, tr, tu, tl, tf, ta, cnt_use;
        repeat (3) @(negedge clock);
        chk("rst_enable", pll_enable, 0);
        chk("rst_resetb", pll_resetb, 0);
        chk("rst_use_pll", use_pll, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_div", pll_div, 8);
        cmp_en = 1;
        resetb = 1'b1;
        @(negedge clock);

        // bring-up; offsets are edges after the edge that sampled start
        pulse_start(ns);
        chk("up_enable", pll_enable, 1);
        wait_sig(1, 1'b1, 200, tr);
        chk("up_resetb_rise", tr - ns, RC);
        wait_sig(2, 1'b1, 200, tu);
        chk("up_use_pll_rise", tu - ns, RC + SC);
        wait_sig(3, 1'b1, 50, tl);
        chk("up_locked_delay", tl - tu, 6);

        // reconfiguration while running
        cfg_valid = 1'b1; cfg_div = 5'd12; cfg_dco = 1'b1; cfg_trim = 26'h3FFFFFF;
        @(negedge clock);
        ns = tb_cyc;
        cfg_valid = 1'b0;
        chk("recfg_locked_drop", locked, 0);
        chk("recfg_use_pll_drop", use_pll, 0);
        chk("recfg_ack_still_high", mux_ack, 1);
        wait_sig(5, 1'b0, 20, ta);
        chk("recfg_ack_after_use", ta > ns, 1);
        wait_sig(1, 1'b0, 20, tr);
        chk("recfg_rst_div", pll_div, 12);
        chk("recfg_rst_dco", pll_dco, 1);
        chk("recfg_rst_trim", pll_trim, 26'h3FFFFFF);
        chk("recfg_rst_enable", pll_enable, 1);
        ns = tr;
        wait_sig(1, 1'b1, 200, tr);
        chk("recfg_resetb_rise", tr - ns, RC);
        wait_sig(3, 1'b1, 200, tl);

        // stop from RUN, then stop during SETTLE
        pulse_stop();
        wait_sig(0, 1'b0, 40, tr);
        pulse_start(ns);
        wait_sig(1, 1'b1, 200, tr);
        repeat (5) @(negedge clock);
        pulse_stop();
        chk("settle_stop_enable", pll_enable, 0);
        chk("settle_stop_ready", cfg_ready, 1);
        cnt_use = 0;
        repeat (100) begin
            @(negedge clock);
            if (use_pll) cnt_use++;
        end
        chk("settle_stop_no_use_pll", cnt_use, 0);

        // stuck mux acknowledge
        stuck = 1;
        pulse_start(ns);
        wait_sig(2, 1'b1, 200, tu);
        wait_sig(4, 1'b1, 100, tf);
        chk("stuck_timeout", tf - tu, AT);
        chk("stuck_use_pll", use_pll, 0);
        chk("stuck_enable", pll_enable, 0);
        stuck = 0;
        pulse_start(ns);
        chk("fault_clear", fault, 0);
        chk("fault_restart_en", pll_enable, 1);
        chk("fault_restart_rb", pll_resetb, 0);
        wait_sig(3, 1'b1, 200, tl);

        // stop and cfg in the same RUN cycle
        cfg_valid = 1'b1; cfg_div = 5'd3; cfg_dco = 1'b0; cfg_trim = 26'h155; stop = 1'b1;
        @(negedge clock);
        cfg_valid = 1'b0; stop = 1'b0;
        chk("both_locked_drop", locked, 0);
        wait_sig(0, 1'b0, 40, tr);
        repeat (40) @(negedge clock);
        chk("both_no_relock", pll_enable, 0);
        chk("both_idle_div", pll_div, 3);
        chk("both_idle_trim", pll_trim, 26'h155);
        pulse_start(ns);
        chk("both_start_div", pll_div, 3);
        chk("both_start_en", pll_enable, 1);

        // asynchronous reset while in SWITCH
        wait_sig(2, 1'b1, 200, tu);
        repeat (2) @(posedge clock);
        #2 resetb = 1'b0;
        #1;
        chk("arst_use_pll", use_pll, 0);
        chk("arst_enable", pll_enable, 0);
        chk("arst_resetb", pll_resetb, 0);
        chk("arst_ready", cfg_ready, 1);
        chk("arst_div", pll_div, 8);
        chk("arst_trim", pll_trim, 0);
        @(negedge clock);
        resetb = 1'b1;
        repeat (3) @(negedge clock);
        chk("arst_idle_enable", pll_enable, 0);
        chk("arst_idle_ready", cfg_ready, 1);
        pulse_start(ns);
        chk("arst_restart_en", pll_enable, 1);
        wait_sig(1, 1'b1, 200, tr);
        chk("arst_restart_rise", tr - ns, RC);

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
